// File: rtl/rlbp_wb_cfg_master.sv
// rlbp_wb_cfg_master: Wishbone initiator that loads the RLBP timing registers
// from a local 16x12-bit shadow table and optionally reads back the SR byte.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start_i; shadow table writable
// WR_REQ | timing-word write on the bus, waiting for ack or timeout
// WR_GAP | one idle bus cycle; absorbs a duplicate ack from the slave
// RD_REQ | SR read on the bus, waiting for ack or timeout
// RD_GAP | one idle bus cycle after the SR read
// DONE   | done_o pulse, busy_o already low, back to IDLE
module rlbp_wb_cfg_master #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned NREGS     = 16,
  parameter logic [7:0]  TIMEOUT   = 8'd255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_idx_i,
  input  logic [11:0] cfg_dat_i,
  input  logic        start_i,
  input  logic        rd_sr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [7:0]  sr_o,
  output logic        sr_valid_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_GAP = 3'd2,
    RD_REQ = 3'd3,
    RD_GAP = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [3:0]  LAST_IDX = 4'(NREGS - 1);
  localparam logic [31:0] SR_ADDR  = BASE_ADDR + 32'd64;

  state_t      state;
  logic [3:0]  idx;
  logic [7:0]  tmo_cnt;
  logic        rd_sr_q;
  logic [11:0] shadow_tbl [16];

  logic [3:0]  idx_nxt;
  logic        tmo_hit;
  logic [23:0] dat_hi_unused;

  assign idx_nxt       = idx + 4'd1;
  // Abort on the cycle the no-ack count would reach TIMEOUT; an ack in that
  // same cycle still wins because it is checked first.
  assign tmo_hit       = (tmo_cnt == TIMEOUT - 8'd1);
  assign dat_hi_unused = wbm_dat_i[31:8];

  function automatic logic [31:0] word_addr(input logic [3:0] i);
    return BASE_ADDR + {26'd0, i, 2'b00};
  endfunction

  // Shadow table: writable only while the sequencer is idle.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < 16; i++) shadow_tbl[i] <= '0;
    end else if (cfg_we_i && state == IDLE) begin
      shadow_tbl[cfg_idx_i] <= cfg_dat_i;
    end
  end

  // Sequencer FSM with registered bus and status outputs.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state      <= IDLE;
      idx        <= '0;
      tmo_cnt    <= '0;
      rd_sr_q    <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      sr_o       <= '0;
      sr_valid_o <= 1'b0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_we_o   <= 1'b0;
      wbm_sel_o  <= '0;
      wbm_adr_o  <= '0;
      wbm_dat_o  <= '0;
    end else begin
      done_o     <= 1'b0;
      sr_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            rd_sr_q   <= rd_sr_i;
            err_o     <= 1'b0;
            idx       <= '0;
            tmo_cnt   <= '0;
            busy_o    <= 1'b1;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_sel_o <= 4'b0001;
            wbm_adr_o <= BASE_ADDR;
            wbm_dat_o <= {20'd0, shadow_tbl[0]};
            state     <= WR_REQ;
          end
        end
        WR_REQ, RD_REQ: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            if (state == RD_REQ) begin
              sr_o       <= wbm_dat_i[7:0];
              sr_valid_o <= 1'b1;
              state      <= RD_GAP;
            end else begin
              state <= WR_GAP;
            end
          end else if (tmo_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            err_o     <= 1'b1;
            done_o    <= 1'b1;
            busy_o    <= 1'b0;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        WR_GAP: begin
          if (idx == LAST_IDX) begin
            if (rd_sr_q) begin
              tmo_cnt   <= '0;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              wbm_we_o  <= 1'b0;
              wbm_sel_o <= 4'hF;
              wbm_adr_o <= SR_ADDR;
              wbm_dat_o <= '0;
              state     <= RD_REQ;
            end else begin
              done_o <= 1'b1;
              busy_o <= 1'b0;
              state  <= DONE;
            end
          end else begin
            idx       <= idx_nxt;
            tmo_cnt   <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= 1'b1;
            wbm_sel_o <= 4'b0001;
            wbm_adr_o <= word_addr(idx_nxt);
            wbm_dat_o <= {20'd0, shadow_tbl[idx_nxt]};
            state     <= WR_REQ;
          end
        end
        RD_GAP: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rlbp_wb_cfg_master.sv
// Testbench for rlbp_wb_cfg_master: behavioural Wishbone responder, negedge
// bus monitor and a table/sequence reference model kept in plain arrays.
module tb_rlbp_wb_cfg_master;

  localparam logic [31:0] BASE   = 32'h3000_0000;
  localparam int          NREGS  = 16;
  localparam int          TMO    = 255;
  localparam logic [31:0] SR_ADR = BASE + 32'd64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [3:0]  cfg_idx_i = '0;
  logic [11:0] cfg_dat_i = '0;
  logic        start_i = 1'b0;
  logic        rd_sr_i = 1'b0;
  logic        busy_o, done_o, err_o, sr_valid_o;
  logic [7:0]  sr_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  rlbp_wb_cfg_master #(.BASE_ADDR(BASE), .NREGS(NREGS), .TIMEOUT(8'(TMO))) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i), .cfg_dat_i(cfg_dat_i),
    .start_i(start_i), .rd_sr_i(rd_sr_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .sr_o(sr_o), .sr_valid_o(sr_valid_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail = 0;

  // reference model and responder controls
  logic [11:0] exp_tbl [16];
  logic [7:0]  sr_val = 8'h00;
  logic        dup_mode = 1'b0;
  int          max_dly = 0;
  logic [31:0] block_adr = 32'hFFFF_FFFF;
  logic [31:0] slow_adr = 32'hFFFF_FFFF;
  int          slow_dly = 0;

  // responder state
  int   wcnt;
  int   cur_dly;
  logic dup_pend;

  // monitor state
  logic [31:0] iss_adr [$];
  logic [31:0] c_adr [$];
  logic [31:0] c_dat [$];
  logic        c_we [$];
  logic [3:0]  c_sel [$];
  int done_cnt = 0, srv_cnt = 0, bus_viol = 0, stb_run = 0, last_run = 0;
  int cyc_n = 0, done_cyc = 0, srv_cyc = 0;
  logic        stb_q = 1'b0;
  logic [68:0] bus_q = '0;
  logic        busy_at_done = 1'b0;

  // Wishbone responder: acks after a programmable wait, optionally twice.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_ack_i <= 1'b0;
      wbm_dat_i <= '0;
      wcnt      <= 0;
      cur_dly   <= 0;
      dup_pend  <= 1'b0;
    end else begin
      wbm_ack_i <= 1'b0;
      if (dup_pend) begin
        wbm_ack_i <= 1'b1;
        dup_pend  <= 1'b0;
      end else if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && wbm_adr_o != block_adr) begin
        if (wcnt >= ((wbm_adr_o == slow_adr) ? slow_dly : cur_dly)) begin
          wbm_ack_i <= 1'b1;
          wcnt      <= 0;
          dup_pend  <= dup_mode;
          cur_dly   <= $urandom_range(0, max_dly);
          wbm_dat_i <= (wbm_adr_o == SR_ADR) ? {24'($urandom), sr_val} : $urandom;
        end else begin
          wcnt <= wcnt + 1;
        end
      end
    end
  end

  // Bus monitor, sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    cyc_n++;
    if (wbm_cyc_o !== wbm_stb_o) bus_viol++;
    if (wbm_stb_o && !stb_q) iss_adr.push_back(wbm_adr_o);
    if (wbm_stb_o && stb_q && {wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o} !== bus_q) bus_viol++;
    if (wbm_stb_o && wbm_ack_i) begin
      c_adr.push_back(wbm_adr_o);
      c_dat.push_back(wbm_dat_o);
      c_we.push_back(wbm_we_o);
      c_sel.push_back(wbm_sel_o);
    end
    if (wbm_stb_o) stb_run++;
    else begin
      if (stb_run > 0) last_run = stb_run;
      stb_run = 0;
    end
    if (done_o) begin done_cnt++; done_cyc = cyc_n; end
    if (sr_valid_o) begin srv_cnt++; srv_cyc = cyc_n; end
    stb_q = wbm_stb_o;
    bus_q = {wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clr_mon();
    iss_adr.delete(); c_adr.delete(); c_dat.delete(); c_we.delete(); c_sel.delete();
    done_cnt = 0; srv_cnt = 0; bus_viol = 0; stb_run = 0; last_run = 0;
    done_cyc = 0; srv_cyc = 0;
  endtask

  task automatic load_table(input bit plan);
    for (int i = 0; i < 16; i++) begin
      cfg_we_i  = 1'b1;
      cfg_idx_i = 4'(i);
      cfg_dat_i = plan ? 12'(12'h100 + i) : 12'($urandom);
      exp_tbl[i] = cfg_dat_i;
      @(negedge clk); #1;
    end
    cfg_we_i = 1'b0;
  endtask

  // Start a sequence and wait for done_o; lat counts mid-cycle samples
  // from the start request until done_o is seen.
  task automatic run_seq(input bit rd, input bit hold, output int lat, output bit to);
    clr_mon();
    start_i = 1'b1;
    rd_sr_i = rd;
    lat = 0;
    to = 1'b1;
    for (int n = 1; n <= 2000; n++) begin
      @(negedge clk); #1;
      if (!hold) begin start_i = 1'b0; rd_sr_i = 1'($urandom_range(0, 1)); end
      if (done_o) begin lat = n; to = 1'b0; busy_at_done = busy_o; break; end
    end
    start_i = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic check_writes(input string nm);
    n_tests++;
    if (c_adr.size() < NREGS) begin
      n_fail++;
      $display("FAIL %s write_count: got %0d want >= %0d", nm, c_adr.size(), NREGS);
    end
    for (int i = 0; i < NREGS && i < c_adr.size(); i++) begin
      n_tests++;
      if ({c_adr[i], c_dat[i], c_we[i], c_sel[i]} !== {BASE + 32'(4 * i), {20'd0, exp_tbl[i]}, 1'b1, 4'h1}) begin
        n_fail++;
        $display("FAIL %s word%0d: got adr %h dat %h we %b sel %h want adr %h dat %h we 1 sel 1",
                 nm, i, c_adr[i], c_dat[i], c_we[i], c_sel[i], BASE + 32'(4 * i), {20'd0, exp_tbl[i]});
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({busy_o, done_o, err_o, sr_valid_o, sr_o} !== 12'h000) begin
      n_fail++; $display("FAIL reset_status: got %h want 000", {busy_o, done_o, err_o, sr_valid_o, sr_o});
    end
    n_tests++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 7'h00) begin
      n_fail++; $display("FAIL reset_bus_ctl: got %h want 00", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o});
    end
    n_tests++;
    if ({wbm_adr_o, wbm_dat_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_bus_data: got %h want 0", {wbm_adr_o, wbm_dat_o});
    end
  endtask

  task automatic test_write_seq();
    int lat; bit to;
    dup_mode = 1'b0; max_dly = 0;
    load_table(1'b1);
    run_seq(1'b0, 1'b0, lat, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL wr_seq_timeout: got 1 want 0"); end
    n_tests++; if (lat !== NREGS * 3 + 1) begin n_fail++; $display("FAIL wr_latency: got %0d want %0d", lat, NREGS * 3 + 1); end
    check_writes("wr_seq");
    n_tests++; if (iss_adr.size() !== NREGS) begin n_fail++; $display("FAIL wr_issue_count: got %0d want %0d", iss_adr.size(), NREGS); end
    n_tests++;
    if ({done_cnt, srv_cnt, bus_viol} !== {32'd1, 32'd0, 32'd0}) begin
      n_fail++; $display("FAIL wr_pulses: got done %0d srv %0d viol %0d want 1 0 0", done_cnt, srv_cnt, bus_viol);
    end
    n_tests++; if ({err_o, busy_o, busy_at_done} !== 3'b000) begin n_fail++; $display("FAIL wr_status: got %b want 000", {err_o, busy_o, busy_at_done}); end
  endtask

  task automatic test_sr_read(input bit dup, input int dly, input string nm);
    int lat; bit to;
    dup_mode = dup; max_dly = dly;
    sr_val = 8'($urandom);
    load_table(1'b0);
    run_seq(1'b1, 1'b0, lat, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got 1 want 0", nm); end
    if (dly == 0 && !dup) begin
      n_tests++; if (lat !== NREGS * 3 + 4) begin n_fail++; $display("FAIL %s_latency: got %0d want %0d", nm, lat, NREGS * 3 + 4); end
    end
    check_writes(nm);
    n_tests++;
    if (c_adr.size() !== NREGS + 1 || {c_adr[NREGS], c_dat[NREGS], c_we[NREGS], c_sel[NREGS]} !== {SR_ADR, 32'h0, 1'b0, 4'hF}) begin
      n_fail++; $display("FAIL %s_sr_txn: got count %0d want %0d with adr %h", nm, c_adr.size(), NREGS + 1, SR_ADR);
    end
    n_tests++;
    if (iss_adr.size() !== NREGS + 1) begin
      n_fail++; $display("FAIL %s_issue_count: got %0d want %0d", nm, iss_adr.size(), NREGS + 1);
    end else begin
      for (int i = 0; i <= NREGS; i++) begin
        n_tests++;
        if (iss_adr[i] !== ((i == NREGS) ? SR_ADR : BASE + 32'(4 * i))) begin
          n_fail++; $display("FAIL %s_issue%0d: got %h", nm, i, iss_adr[i]);
        end
      end
    end
    n_tests++; if (sr_o !== sr_val) begin n_fail++; $display("FAIL %s_sr_value: got %h want %h", nm, sr_o, sr_val); end
    n_tests++;
    if (srv_cnt !== 1 || done_cnt !== 1 || !(srv_cyc < done_cyc)) begin
      n_fail++; $display("FAIL %s_pulses: got srv %0d done %0d srv@%0d done@%0d want 1 1 srv first", nm, srv_cnt, done_cnt, srv_cyc, done_cyc);
    end
    n_tests++; if ({err_o, bus_viol} !== {1'b0, 32'd0}) begin n_fail++; $display("FAIL %s_err_viol: got err %b viol %0d want 0 0", nm, err_o, bus_viol); end
    dup_mode = 1'b0; max_dly = 0;
  endtask

  task automatic test_timeout();
    int lat; bit to;
    load_table(1'b0);
    block_adr = BASE + 32'h0C;
    run_seq(1'b1, 1'b0, lat, to);
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL tmo_seq_timeout: got 1 want 0"); end
    n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", err_o); end
    n_tests++;
    if (iss_adr.size() !== 4 || iss_adr[3] !== BASE + 32'h0C || c_adr.size() !== 3) begin
      n_fail++; $display("FAIL tmo_attempts: got issued %0d completed %0d want 4 3", iss_adr.size(), c_adr.size());
    end
    n_tests++; if (last_run !== TMO) begin n_fail++; $display("FAIL tmo_stb_cycles: got %0d want %0d", last_run, TMO); end
    n_tests++; if ({srv_cnt, done_cnt} !== {32'd0, 32'd1}) begin n_fail++; $display("FAIL tmo_pulses: got srv %0d done %0d want 0 1", srv_cnt, done_cnt); end
    block_adr = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    n_tests++; if (err_o !== 1'b1) begin n_fail++; $display("FAIL tmo_err_sticky: got %b want 1", err_o); end
    fork
      run_seq(1'b0, 1'b0, lat, to);
      begin
        @(negedge clk); #1;
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: got %b want 0", err_o); end
      end
    join
    check_writes("tmo_rerun");
    n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL tmo_rerun_err: got %b want 0", err_o); end
  endtask

  task automatic test_ack_at_limit();
    int lat; bit to;
    load_table(1'b0);
    slow_adr = BASE + 32'h14;
    slow_dly = TMO - 2;
    run_seq(1'b0, 1'b0, lat, to);
    slow_adr = 32'hFFFF_FFFF;
    n_tests++; if ({to, err_o} !== 2'b00) begin n_fail++; $display("FAIL limit_err: got to %b err %b want 0 0", to, err_o); end
    check_writes("limit");
    n_tests++; if (c_adr.size() !== NREGS) begin n_fail++; $display("FAIL limit_count: got %0d want %0d", c_adr.size(), NREGS); end
  endtask

  task automatic test_busy_ignores();
    int lat; bit to;
    load_table(1'b0);
    fork
      run_seq(1'b0, 1'b1, lat, to);
      begin
        repeat (10) @(negedge clk);
        #1;
        cfg_we_i = 1'b1; cfg_idx_i = 4'd0; cfg_dat_i = 12'hFFF;
        @(negedge clk); #1;
        cfg_we_i = 1'b0;
      end
    join
    n_tests++; if (to !== 1'b0) begin n_fail++; $display("FAIL busy_seq_timeout: got 1 want 0"); end
    n_tests++; if (iss_adr.size() !== NREGS) begin n_fail++; $display("FAIL busy_no_restart: got %0d issues want %0d", iss_adr.size(), NREGS); end
    n_tests++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: got %b want 0", busy_o); end
    run_seq(1'b0, 1'b0, lat, to);
    check_writes("busy_readback");
  endtask

  task automatic test_reset_mid();
    int lat; bit to;
    bit hit = 1'b0;
    load_table(1'b0);
    clr_mon();
    rd_sr_i = 1'b0; start_i = 1'b1;
    for (int n = 0; n < 400 && !hit; n++) begin
      @(negedge clk); #1;
      start_i = 1'b0;
      if (wbm_stb_o && wbm_adr_o == BASE + 32'h1C) hit = 1'b1;
    end
    n_tests++; if (hit !== 1'b1) begin n_fail++; $display("FAIL rst_reach_word7: got 0 want 1"); end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({wbm_cyc_o, wbm_stb_o, busy_o} !== 3'b000) begin
      n_fail++; $display("FAIL rst_async: got cyc/stb/busy %b want 000", {wbm_cyc_o, wbm_stb_o, busy_o});
    end
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) exp_tbl[i] = '0;
    clr_mon();
    repeat (6) @(negedge clk);
    #1;
    n_tests++;
    if (busy_o !== 1'b0 || iss_adr.size() !== 0) begin
      n_fail++; $display("FAIL rst_idle: got busy %b issues %0d want 0 0", busy_o, iss_adr.size());
    end
    test_reset();
    run_seq(1'b0, 1'b0, lat, to);
    check_writes("rst_zero_tbl");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    test_reset();
    test_write_seq();
    test_sr_read(1'b0, 0, "sr_read");
    test_sr_read(1'b1, 0, "dup_ack");
    test_sr_read(1'b1, 3, "dup_wait");
    test_sr_read(1'b0, 4, "rand_wait");
    test_timeout();
    test_ack_at_limit();
    test_busy_ignores();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rlbp_wb_cfg_master.md
Name: rlbp_wb_cfg_master

Overview:
- Wishbone initiator that programs the RLBP macro's 16 timing registers from a local 16x12-bit shadow table, then optionally reads back the 8-bit SR register.
- Sits between the LA/test logic and the RLBP Wishbone slave, so a full timing configuration can be loaded with one start pulse instead of 16 firmware bus writes.
- Targets the slave's register map: offset 4*i for timing word i (i = 0..15); SR at offset 64.

Parameters:
- BASE_ADDR, 32'h3000_0000, Wishbone base address of the RLBP slave (upper nibble must be 3).
- NREGS, 16, number of timing words written per sequence; range 1..16.
- TIMEOUT, 255, maximum cycles to wait for wbm_ack_i per transaction; 8-bit counter.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  asynchronous active-low reset.
- cfg_we_i  in  1  shadow-table write strobe; ignored while busy_o=1.
- cfg_idx_i  in  4  shadow-table index.
- cfg_dat_i  in  12  shadow-table data.
- start_i  in  1  level-sampled; starts a sequence when high in IDLE.
- rd_sr_i  in  1  sampled with start_i; 1 = read SR after the writes.
- busy_o  out  1  high from the cycle after start is accepted until DONE.
- done_o  out  1  one-cycle pulse at sequence end, including error ends.
- err_o  out  1  sticky timeout flag; cleared when the next start is accepted.
- sr_o  out  8  captured wbm_dat_i[7:0] from the SR read.
- sr_valid_o  out  1  one-cycle pulse when sr_o updates.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte select.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset: wb_rst_ni=0 asynchronously clears all of the following, at any point mid-sequence; no bus cycle resumes after reset release.
  - All outputs 0.
  - Shadow table all 0.
  - FSM to IDLE; idx=0; timeout counter=0.
- Table writes: when cfg_we_i=1 and the FSM is in IDLE, table[cfg_idx_i] <= cfg_dat_i on the next clock edge.
- All Wishbone outputs are registered. wbm_cyc_o = wbm_stb_o at all times.
- States: IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE.
- IDLE:
  - On start_i=1: latch rd_sr_i; clear err_o and idx; go to WR_REQ.
  - wbm_cyc_o and wbm_stb_o go high in the next cycle.
  - start_i in any other state is ignored.
- WR_REQ:
  - Drive wbm_we_o=1, wbm_sel_o=4'b0001.
  - Drive wbm_adr_o = BASE_ADDR + 4*idx, wbm_dat_o = {20'b0, table[idx]}.
  - On wbm_ack_i=1: deassert cyc/stb at the next edge and go to WR_GAP.
  - Bus signals are stable while waiting for ack.
- WR_GAP:
  - Exactly one idle bus cycle (cyc/stb=0), so that a duplicate ack from the registered-ack slave is absorbed.
  - Any ack seen in a GAP state, or in IDLE, is ignored.
  - Then: if idx = NREGS-1, go to RD_REQ when rd_sr_i was latched as 1, else to DONE. Otherwise idx+1 and back to WR_REQ.
- RD_REQ:
  - Drive wbm_we_o=0, wbm_sel_o=4'hF, wbm_adr_o = BASE_ADDR+64, wbm_dat_o=0.
  - On ack: sr_o <= wbm_dat_i[7:0], pulse sr_valid_o in the next cycle, go to RD_GAP.
- RD_GAP: one idle cycle, then DONE.
- DONE: done_o=1 for one cycle, busy_o drops in the same cycle, return to IDLE.
- Timeout:
  - The counter clears on entry to each REQ state and increments every cycle without ack.
  - When it reaches TIMEOUT with no ack: drop cyc/stb, set err_o=1, go to DONE. Remaining writes and the SR read are skipped; sr_valid_o does not pulse.
- Ack in the same cycle the counter reaches TIMEOUT counts as success; no error.
- Latency, zero-wait slave (ack one cycle after stb):
  - Each transaction takes 3 cycles (REQ, ack cycle, GAP).
  - Full 16-write sequence: start accepted to done_o = 48 cycles + 1; +3 with SR read.

Test Plan:
- Load table[i] = 12'h100+i, start with rd_sr_i=0, zero-wait responder model -> 16 writes to 0x3000_0000 .. 0x3000_003C, data 0x100..0x10F, sel=1, no address repeated, one done_o pulse, err_o=0.
- Same load, rd_sr_i=1, responder returns 0x0000_00A5 on the read of 0x3000_0040 -> sr_o=8'hA5, sr_valid_o pulses exactly once, before done_o.
- Responder acks for 2 consecutive cycles per request (duplicate ack) -> each address is still issued exactly once; the GAP absorbs the extra ack.
- Responder never acks word 3 -> cyc/stb drop after 255 cycles; err_o=1; only addresses 0x00..0x0C attempted; done_o pulses; next start clears err_o.
- cfg_we_i pulsed mid-sequence with idx 0, data 12'hFFF -> table unchanged (a readback sequence shows the original value); start_i held high during busy does not restart the sequence.
- Assert wb_rst_ni=0 during word 7's WR_REQ -> cyc/stb go low immediately (asynchronous); after release, FSM is in IDLE, busy_o=0, table is all zero.
